// File: rtl/mem_store_ctrl.sv
// Store path: captures a store, formats byte lanes/enables, runs a req/ack write to data memory.
// Latency: mem_req rises the edge after store_req; store_done pulses the cycle after the accepting mem_ack.
// Backpressure: holds the bus request until mem_ack or ACK_TIMEOUT cycles elapse; store_req while busy is dropped.
module mem_store_ctrl #(
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        store_req,
    input  logic [2:0]  store_funct3,
    input  logic [31:0] store_addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        store_done,
    output logic        store_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  cnt;
    logic [31:0] lane_wdata;
    logic [3:0]  lane_be;
    logic        lane_ok;
    logic        accept;

    // Byte-lane formatting and alignment check for the incoming request
    always_comb begin
        lane_wdata = store_data;
        lane_be    = 4'b0000;
        lane_ok    = 1'b0;
        case (store_funct3)
            3'b000: begin
                lane_wdata = {4{store_data[7:0]}};
                lane_be    = 4'b0001 << store_addr[1:0];
                lane_ok    = 1'b1;
            end
            3'b001: begin
                lane_wdata = {2{store_data[15:0]}};
                lane_be    = store_addr[1] ? 4'b1100 : 4'b0011;
                lane_ok    = ~store_addr[0];
            end
            3'b010: begin
                lane_wdata = store_data;
                lane_be    = 4'b1111;
                lane_ok    = (store_addr[1:0] == 2'b00);
            end
            default: begin
                lane_ok    = 1'b0;
            end
        endcase
    end

    assign accept = (state == IDLE) && store_req;

    // Next-state logic; an ack on the timeout edge still counts as success
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (store_req) begin
                    state_nxt = lane_ok ? BUS : ERR;
                end
            end
            BUS: begin
                if (mem_ack) begin
                    state_nxt = DONE;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = ERR;
                end
            end
            DONE:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Wait counter: zero on BUS entry, counts every BUS cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= 8'd0;
        end else if (state == BUS) begin
            cnt <= cnt + 8'd1;
        end else begin
            cnt <= 8'd0;
        end
    end

    // Registered outputs decoded from the next state; bus fields load only on a legal capture
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy       <= 1'b0;
            store_done <= 1'b0;
            store_err  <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
            mem_be     <= 4'd0;
        end else begin
            busy       <= (state_nxt != IDLE);
            store_done <= (state_nxt == DONE) || (state_nxt == ERR);
            store_err  <= (state_nxt == ERR);
            mem_req    <= (state_nxt == BUS);
            mem_we     <= (state_nxt == BUS);
            if (accept && lane_ok) begin
                mem_addr  <= {store_addr[31:2], 2'b00};
                mem_wdata <= lane_wdata;
                mem_be    <= lane_be;
            end
        end
    end

endmodule

// File: tb/tb_mem_store_ctrl.sv
// Bench for mem_store_ctrl: directed scenarios plus randomized stores against a lane-level model.
// Inputs change 1 time unit after the rising edge, outputs are sampled at that same point.
// The bench plays the memory, acking on a chosen bus cycle or never.
module tb_mem_store_ctrl;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        store_req = 1'b0;
    logic [2:0]  store_funct3 = 3'd0;
    logic [31:0] store_addr = 32'd0;
    logic [31:0] store_data = 32'd0;
    logic        busy;
    logic        store_done;
    logic        store_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    mem_store_ctrl #(.ACK_TIMEOUT(T)) dut (
        .clk          (clk),
        .rst          (rst),
        .store_req    (store_req),
        .store_funct3 (store_funct3),
        .store_addr   (store_addr),
        .store_data   (store_data),
        .busy         (busy),
        .store_done   (store_done),
        .store_err    (store_err),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_be       (mem_be),
        .mem_ack      (mem_ack)
    );

    always #5 clk = ~clk;

    // One full store: ack_cyc is the bus cycle (1-based) on which memory acks, 0 or >T means never.
    // poke drives conflicting requests while busy, which must be ignored.
    task automatic run_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                             input int ack_cyc, input bit poke, input string tag);
        int          size;
        int          off;
        int          nbus;
        bit          legal;
        bit          exp_err;
        logic [3:0]  ebe;
        logic [31:0] ewd;
        size  = (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : (f3 == 3'b010) ? 4 : 0;
        legal = (size != 0) && ((a % size) == 0);
        off   = int'(a[1:0]);
        ebe   = 4'b0000;
        ewd   = 32'd0;
        if (size != 0) begin
            for (int i = 0; i < 4; i++) begin
                if (i >= off && i < off + size) ebe[i] = 1'b1;
                ewd[8*i +: 8] = d[8*(i % size) +: 8];
            end
        end
        nbus    = (ack_cyc >= 1 && ack_cyc <= T) ? ack_cyc : T;
        exp_err = !legal || !(ack_cyc >= 1 && ack_cyc <= T);

        store_funct3 = f3;
        store_addr   = a;
        store_data   = d;
        store_req    = 1'b1;
        @(posedge clk); #1;
        store_req    = 1'b0;
        store_addr   = $urandom;
        store_data   = $urandom;
        store_funct3 = 3'($urandom);

        if (legal) begin
            for (int k = 1; k <= nbus; k++) begin
                n_cmp++;
                if ({busy, mem_req, mem_we, store_done, store_err} !== 5'b11100) begin
                    n_bad++;
                    $display("FAIL %s bus_ctl cyc %0d: got %b want 11100", tag, k,
                             {busy, mem_req, mem_we, store_done, store_err});
                end
                n_cmp++;
                if ({mem_addr, mem_wdata, mem_be} !== {a[31:2], 2'b00, ewd, ebe}) begin
                    n_bad++;
                    $display("FAIL %s bus_dat cyc %0d: got %h/%h/%b want %h/%h/%b", tag, k,
                             mem_addr, mem_wdata, mem_be, {a[31:2], 2'b00}, ewd, ebe);
                end
                mem_ack = (k == ack_cyc);
                if (poke) begin
                    store_req    = 1'b1;
                    store_funct3 = 3'b010;
                    store_addr   = $urandom & 32'hFFFF_FFFC;
                    store_data   = $urandom;
                end
                @(posedge clk); #1;
                mem_ack   = 1'b0;
                store_req = 1'b0;
            end
        end

        n_cmp++;
        if ({busy, mem_req, mem_we, store_done, store_err} !== {4'b1001, exp_err}) begin
            n_bad++;
            $display("FAIL %s end_ctl: got %b want %b", tag,
                     {busy, mem_req, mem_we, store_done, store_err}, {4'b1001, exp_err});
        end
        if (poke) begin
            store_req = 1'b1;
            mem_ack   = 1'b1;
        end
        @(posedge clk); #1;
        store_req = 1'b0;
        mem_ack   = 1'b0;
        n_cmp++;
        if ({busy, mem_req, store_done, store_err} !== 4'b0000) begin
            n_bad++;
            $display("FAIL %s idle_ctl: got %b want 0000", tag, {busy, mem_req, store_done, store_err});
        end
    endtask

    task automatic test_reset();
        store_req    = 1'b1;
        store_funct3 = 3'b010;
        store_addr   = 32'h0000_0040;
        mem_ack      = 1'b1;
        rst          = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, mem_req, mem_we, store_done, store_err, mem_addr, mem_wdata, mem_be} !== 73'd0) begin
            n_bad++;
            $display("FAIL reset: got %b/%h/%h/%b want all zero",
                     {busy, mem_req, mem_we, store_done, store_err}, mem_addr, mem_wdata, mem_be);
        end
        store_req = 1'b0;
        mem_ack   = 1'b0;
        rst       = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({busy, mem_req, store_done} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_idle: got %b want 000", {busy, mem_req, store_done});
        end
    endtask

    task automatic test_directed();
        run_store(3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 1, 1'b0, "sw");
        run_store(3'b000, 32'h0000_0203, 32'h0000_00A5, 2, 1'b0, "sb");
        run_store(3'b001, 32'h0000_0202, 32'h0000_1234, 3, 1'b0, "sh");
    endtask

    task automatic test_errors();
        run_store(3'b010, 32'h0000_0102, 32'h1111_2222, 1, 1'b0, "sw_mis");
        run_store(3'b001, 32'h0000_0101, 32'h3333_4444, 1, 1'b0, "sh_mis");
        run_store(3'b011, 32'h0000_0100, 32'h5555_6666, 1, 1'b0, "f3_ill");
    endtask

    task automatic test_timeout();
        run_store(3'b010, 32'h0000_0400, 32'hCAFE_F00D, 0, 1'b0, "timeout");
        run_store(3'b010, 32'h0000_0404, 32'h0BAD_CAFE, T, 1'b0, "ack_last");
    endtask

    task automatic test_reset_in_bus();
        store_funct3 = 3'b010;
        store_addr   = 32'h0000_0300;
        store_data   = 32'h1234_5678;
        store_req    = 1'b1;
        @(posedge clk); #1;
        store_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (mem_req !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_bus_pre: got mem_req %b want 1", mem_req);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({busy, mem_req, mem_we, store_done, store_err, mem_addr, mem_wdata, mem_be} !== 73'd0) begin
            n_bad++;
            $display("FAIL rst_bus: got %b/%h/%h/%b want all zero",
                     {busy, mem_req, mem_we, store_done, store_err}, mem_addr, mem_wdata, mem_be);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({busy, store_done} !== 2'b00) begin
            n_bad++;
            $display("FAIL rst_bus_after: got %b want 00", {busy, store_done});
        end
        run_store(3'b010, 32'h0000_0308, 32'h8765_4321, 2, 1'b0, "post_rst");
    endtask

    task automatic test_back_to_back();
        run_store(3'b010, 32'h0000_0500, 32'hA1A2_A3A4, 4, 1'b1, "b2b_0");
        run_store(3'b000, 32'h0000_0501, 32'h0000_00C3, 1, 1'b1, "b2b_1");
        run_store(3'b001, 32'h0000_0506, 32'h0000_BEEF, 0, 1'b1, "b2b_2");
    endtask

    task automatic test_random();
        for (int it = 0; it < 30; it++) begin
            int          r;
            logic [2:0]  f3;
            logic [31:0] a;
            r  = int'($urandom_range(0, 9));
            f3 = (r < 9) ? 3'(r % 3) : 3'($urandom_range(3, 7));
            a  = $urandom;
            if ($urandom_range(0, 2) != 0) a = a & 32'hFFFF_FFFC;
            run_store(f3, a, $urandom, int'($urandom_range(0, 20)), bit'($urandom_range(0, 1)), "rand");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_errors();
        test_timeout();
        test_reset_in_bus();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_store_ctrl.md
Name: mem_store_ctrl

Overview:
- Write-side counterpart of the memory data register path in the multi-cycle datapath.
- Captures a store request from the control FSM: address, register data and funct3.
- Formats the data into byte lanes with matching byte enables, then runs a req/ack write handshake to data memory.
- Reports completion or error back to the control FSM.

Parameters:
ACK_TIMEOUT, 16, number of cycles in BUS without mem_ack before the store is aborted with an error (legal range 2..255)

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  reset, synchronous, active-low; sampled on the clk rising edge
store_req  input  1  one-cycle store request from the control FSM; ignored unless state is IDLE
store_funct3  input  3  store width: 000=SB, 001=SH, 010=SW; all other codes are illegal
store_addr  input  32  byte address from the ALU result
store_data  input  32  rs2 value
busy  output  1  high whenever state is not IDLE
store_done  output  1  one-cycle pulse when the store terminates (success or error)
store_err  output  1  high together with store_done when the store is misaligned, has an illegal funct3, or times out
mem_req  output  1  memory write request
mem_we  output  1  write enable; equal to mem_req
mem_addr  output  32  word address {store_addr[31:2],2'b00}
mem_wdata  output  32  lane-replicated write data
mem_be  output  4  byte enables; bit i selects byte lane i, bits 7+8i..8i
mem_ack  input  1  memory accepted the write; sampled only in BUS

Behaviour:
- All outputs are registered.
- Reset (rst==0 at a clk edge): state=IDLE, timeout counter=0. busy, store_done, store_err, mem_req and mem_we become 0, and mem_addr, mem_wdata and mem_be become 0 after that edge. Reset overrides every other event, including an in-flight BUS cycle; mem_req drops at that same edge.
- State machine: IDLE, BUS, DONE, ERR.
- IDLE, store_req=1:
  - Latch addr, data and funct3; compute lanes.
  - SB: wdata={4{data[7:0]}}, be=4'b0001<<addr[1:0].
  - SH: wdata={2{data[15:0]}}, be = addr[1] ? 4'b1100 : 4'b0011.
  - SW: wdata=data, be=4'b1111.
  - Error cases: SH with addr[0]=1, SW with addr[1:0]!=0, or any illegal funct3 -> ERR. mem_req stays 0 and no memory access occurs.
  - Otherwise -> BUS.
- IDLE, store_req=0: remain in IDLE.
- BUS:
  - mem_req=mem_we=1; mem_addr, mem_wdata and mem_be hold stable for the whole state.
  - Counter starts at 0 on entry and increments every cycle.
  - mem_ack=1 at an edge -> DONE; mem_req=0 after that edge.
  - Otherwise, if counter==ACK_TIMEOUT-1 -> ERR; mem_req=0 after that edge.
  - If mem_ack and the timeout occur at the same edge, ack wins.
- DONE: store_done=1, store_err=0 for exactly one cycle, then IDLE.
- ERR: store_done=1, store_err=1 for exactly one cycle, then IDLE.
- Latency:
  - store_req sampled at edge E0 -> mem_req high from E0.
  - If mem_ack=1 at E1 -> store_done high for the cycle after E1; busy falls at E2.
  - Minimum store_req-to-store_done spacing is 2 edges.
  - Misaligned or illegal store: store_done/store_err high for the cycle after E0.
- busy is high in BUS, DONE and ERR.
- store_req while busy is dropped: no queueing and no effect on latched values.
- A new store_req is accepted on the first edge busy=0, i.e. back-to-back stores are allowed with one IDLE cycle between them.
- Latched data and address are unaffected by store_data/store_addr changes after capture.
- mem_ack outside BUS is ignored.

Test Plan:
- SW, addr=0x00000100, data=0xDEADBEEF, mem_ack one cycle after mem_req rises -> mem_addr=0x00000100, mem_wdata=0xDEADBEEF, mem_be=1111; store_done pulse 1 cycle with store_err=0; busy low afterwards.
- SB, data=0x000000A5, addr=0x203 -> mem_addr=0x200, mem_wdata=0xA5A5A5A5, mem_be=1000. SH, data=0x00001234, addr=0x202 -> mem_wdata=0x12341234, mem_be=1100.
- Misaligned and illegal requests -> store_done and store_err high one cycle after the request; mem_req never asserts:
  - SW at 0x102.
  - SH at 0x101.
  - funct3=011.
- mem_ack held low, ACK_TIMEOUT=16 -> mem_req high exactly 16 cycles, then store_done=store_err=1. Variant: ack on the 16th cycle -> success, store_err=0.
- rst driven low during BUS, after 3 cycles of waiting -> next edge mem_req=0, busy=0, no store_done. With rst high again, a new SW completes normally.
- store_req pulsed while busy, with different addr/data -> ignored; memory sees only the first transaction's values. A request in the first IDLE cycle after done is accepted.
